// File: rtl/complex_dot_stream.sv
// Streaming complex dot-product engine: LANES complex MACs per beat, lane-summed,
// accumulated over cfg_len_i beats, stall-based handshake on a single global enable.
module complex_dot_stream #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [LEN_W-1:0]          cfg_len_i,
  input  logic                      cfg_conj_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   a_re_i,
  input  logic [LANES*DATA_W-1:0]   a_im_i,
  input  logic [LANES*DATA_W-1:0]   b_re_i,
  input  logic [LANES*DATA_W-1:0]   b_im_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [ACC_W-1:0]   res_re_o,
  output logic signed [ACC_W-1:0]   res_im_o,
  output logic                      res_ovf_o,
  output logic                      busy_o
);
  localparam int PW    = 2*DATA_W + 1;
  localparam int SUM_W = 2*DATA_W + 2 + $clog2(LANES);

  logic                    en, accept, first, last;
  logic [LEN_W-1:0]        cnt_q, len_q, len_eff;
  logic                    conj_q, conj_eff;

  logic signed [DATA_W-1:0]   ar [LANES];
  logic signed [DATA_W-1:0]   ai [LANES];
  logic signed [DATA_W-1:0]   br [LANES];
  logic signed [DATA_W-1:0]   bi [LANES];
  logic signed [2*DATA_W-1:0] rr [LANES];
  logic signed [2*DATA_W-1:0] ii [LANES];
  logic signed [2*DATA_W-1:0] ri [LANES];
  logic signed [2*DATA_W-1:0] ir [LANES];
  logic signed [PW-1:0]       p_re_d [LANES];
  logic signed [PW-1:0]       p_im_d [LANES];
  logic signed [PW-1:0]       p_re_q [LANES];
  logic signed [PW-1:0]       p_im_q [LANES];
  logic                       s1_v_q, s1_last_q;

  logic signed [SUM_W-1:0]    lsum_re_d, lsum_im_d, lsum_re_q, lsum_im_q;
  logic                       s2_v_q, s2_last_q;

  logic signed [ACC_W-1:0]    acc_re_q, acc_im_q, ext_re, ext_im, sum_re, sum_im;
  logic                       sticky_q, ovf_re, ovf_im, beat_ovf;

  assign en         = !(out_valid_o && !out_ready_i);
  assign in_ready_o = en && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = s1_v_q || s2_v_q || out_valid_o || (cnt_q != '0);

  // Config is live on the first beat of a product and latched for the rest.
  assign first    = (cnt_q == '0);
  assign len_eff  = first ? ((cfg_len_i == '0) ? LEN_W'(1) : cfg_len_i) : len_q;
  assign conj_eff = first ? cfg_conj_i : conj_q;
  assign last     = (cnt_q == len_eff - LEN_W'(1));

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      ar[k] = $signed(a_re_i[k*DATA_W +: DATA_W]);
      ai[k] = $signed(a_im_i[k*DATA_W +: DATA_W]);
      br[k] = $signed(b_re_i[k*DATA_W +: DATA_W]);
      bi[k] = $signed(b_im_i[k*DATA_W +: DATA_W]);
      rr[k] = ar[k] * br[k];
      ii[k] = ai[k] * bi[k];
      ri[k] = ar[k] * bi[k];
      ir[k] = ai[k] * br[k];
      if (conj_eff) begin
        p_re_d[k] = PW'(rr[k]) + PW'(ii[k]);
        p_im_d[k] = PW'(ir[k]) - PW'(ri[k]);
      end else begin
        p_re_d[k] = PW'(rr[k]) - PW'(ii[k]);
        p_im_d[k] = PW'(ri[k]) + PW'(ir[k]);
      end
    end
  end

  always_comb begin
    lsum_re_d = '0;
    lsum_im_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lsum_re_d = lsum_re_d + SUM_W'(p_re_q[k]);
      lsum_im_d = lsum_im_d + SUM_W'(p_im_q[k]);
    end
  end

  always_comb begin
    ext_re   = ACC_W'(lsum_re_q);
    ext_im   = ACC_W'(lsum_im_q);
    sum_re   = acc_re_q + ext_re;
    sum_im   = acc_im_q + ext_im;
    ovf_re   = (acc_re_q[ACC_W-1] == ext_re[ACC_W-1]) && (sum_re[ACC_W-1] != acc_re_q[ACC_W-1]);
    ovf_im   = (acc_im_q[ACC_W-1] == ext_im[ACC_W-1]) && (sum_im[ACC_W-1] != acc_im_q[ACC_W-1]);
    beat_ovf = ovf_re || ovf_im;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      len_q       <= '0;
      conj_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      p_re_q      <= '{default: '0};
      p_im_q      <= '{default: '0};
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      lsum_re_q   <= '0;
      lsum_im_q   <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      sticky_q    <= 1'b0;
      out_valid_o <= 1'b0;
      res_re_o    <= '0;
      res_im_o    <= '0;
      res_ovf_o   <= 1'b0;
    end else if (flush_i) begin
      cnt_q       <= '0;
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      sticky_q    <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (en) begin
      if (accept) begin
        cnt_q <= last ? '0 : cnt_q + LEN_W'(1);
        if (first) begin
          len_q  <= len_eff;
          conj_q <= cfg_conj_i;
        end
      end
      s1_v_q      <= accept;
      s1_last_q   <= last;
      p_re_q      <= p_re_d;
      p_im_q      <= p_im_d;
      s2_v_q      <= s1_v_q;
      s2_last_q   <= s1_last_q;
      lsum_re_q   <= lsum_re_d;
      lsum_im_q   <= lsum_im_d;
      // en=1 means any held result is consumed this edge, so a new one may replace it.
      out_valid_o <= 1'b0;
      if (s2_v_q) begin
        if (s2_last_q) begin
          res_re_o    <= sum_re;
          res_im_o    <= sum_im;
          res_ovf_o   <= sticky_q || beat_ovf;
          out_valid_o <= 1'b1;
          acc_re_q    <= '0;
          acc_im_q    <= '0;
          sticky_q    <= 1'b0;
        end else begin
          acc_re_q <= sum_re;
          acc_im_q <= sum_im;
          sticky_q <= sticky_q || beat_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_dot_stream.sv
// Scoreboard bench for complex_dot_stream: a reference model pushes expected results
// as products are driven; a monitor pops and compares on each output handshake.
module tb_complex_dot_stream;
  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 36;
  localparam int LEN_W  = 8;
  localparam int VW     = LANES*DATA_W;

  logic             clk, rst_n, flush, cfg_conj, in_valid, in_ready;
  logic [LEN_W-1:0] cfg_len;
  logic [VW-1:0]    a_re, a_im, b_re, b_im;
  logic             out_valid, out_ready, res_ovf, busy;
  logic [ACC_W-1:0] res_re, res_im;

  typedef struct {longint re; longint im; bit ovf;} exp_t;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_results = 0;

  complex_dot_stream #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cfg_len_i(cfg_len), .cfg_conj_i(cfg_conj),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .res_re_o(res_re), .res_im_o(res_im), .res_ovf_o(res_ovf), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        check("res_re", $signed(res_re), e.re);
        check("res_im", $signed(res_im), e.im);
        check("res_ovf", {63'd0, res_ovf}, {63'd0, e.ovf});
      end
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((sb.size() != 0 || busy) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Sends nbeats beats; cfg is garbled after the first beat to show it is ignored.
  task automatic send_product(input int len, input bit conj, input int nbeats, input bit rnd,
                              input int ar, input int ai, input int br, input int bi, input bit push);
    longint acc_re = 0, acc_im = 0, s;
    bit     ovf = 1'b0;
    exp_t   e;
    for (int b = 0; b < nbeats; b++) begin
      longint x_re = 0, x_im = 0;
      for (int k = 0; k < LANES; k++) begin
        logic [DATA_W-1:0] lar, lai, lbr, lbi;
        longint sar, sai, sbr, sbi;
        lar = rnd ? DATA_W'($urandom_range(0, 65535)) : DATA_W'(ar);
        lai = rnd ? DATA_W'($urandom_range(0, 65535)) : DATA_W'(ai);
        lbr = rnd ? DATA_W'($urandom_range(0, 65535)) : DATA_W'(br);
        lbi = rnd ? DATA_W'($urandom_range(0, 65535)) : DATA_W'(bi);
        a_re[k*DATA_W +: DATA_W] = lar;
        a_im[k*DATA_W +: DATA_W] = lai;
        b_re[k*DATA_W +: DATA_W] = lbr;
        b_im[k*DATA_W +: DATA_W] = lbi;
        sar = longint'($signed(lar));
        sai = longint'($signed(lai));
        sbr = longint'($signed(lbr));
        sbi = longint'($signed(lbi));
        if (!conj) begin
          x_re += sar*sbr - sai*sbi;
          x_im += sar*sbi + sai*sbr;
        end else begin
          x_re += sar*sbr + sai*sbi;
          x_im += sai*sbr - sar*sbi;
        end
      end
      if (b == 0) begin
        cfg_len  = LEN_W'(len);
        cfg_conj = conj;
      end else begin
        cfg_len  = LEN_W'(1);
        cfg_conj = !conj;
      end
      in_valid = 1'b1;
      wait_accept();
      s = wrap(acc_re + x_re);
      if (((acc_re < 0) == (x_re < 0)) && ((s < 0) != (acc_re < 0))) ovf = 1'b1;
      acc_re = s;
      s = wrap(acc_im + x_im);
      if (((acc_im < 0) == (x_im < 0)) && ((s < 0) != (acc_im < 0))) ovf = 1'b1;
      acc_im = s;
    end
    in_valid = 1'b0;
    if (push) begin
      e.re = acc_re; e.im = acc_im; e.ovf = ovf;
      sb.push_back(e);
    end
  endtask

  initial begin
    int lat, seen, nr;
    rst_n = 1'b0; flush = 1'b0; cfg_len = '0; cfg_conj = 1'b0; in_valid = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_res_re", $signed(res_re), 0);
    check("rst_res_ovf", {63'd0, res_ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Single beat with latency measurement: expect -20+40j
    send_product(1, 1'b0, 1, 1'b0, 1, 2, 3, 4, 1'b1);
    lat = 0; seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
    end
    check("latency", lat, 3);
    wait_idle();

    // Conjugate, 3 beats, one result 132+24j
    nr = n_results;
    send_product(3, 1'b1, 3, 1'b0, 1, 2, 3, 4, 1'b1);
    wait_idle();
    check("conj_result_count", n_results - nr, 1);

    // len=0 treated as one beat
    send_product(0, 1'b0, 1, 1'b0, 5, -3, -7, 2, 1'b1);
    wait_idle();

    // Random operands, both modes, back-to-back products
    for (int t = 0; t < 6; t++)
      send_product($urandom_range(1, 4), 1'(t), 0, 1'b0, 0, 0, 0, 0, 1'b0);
    wait_idle();
    for (int t = 0; t < 6; t++) begin
      int l;
      l = $urandom_range(1, 4);
      send_product(l, 1'(t), l, 1'b1, 0, 0, 0, 0, 1'b1);
    end
    wait_idle();

    // Backpressure: hold first result, pipeline stalls
    nr = n_results;
    out_ready = 1'b0;
    send_product(1, 1'b0, 1, 1'b0, 1, 0, 1, 0, 1'b1);
    send_product(1, 1'b0, 1, 1'b0, 2, 0, 1, 0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("bp_out_valid", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {63'd0, in_ready}, 0);
      check("bp_hold_re", $signed(res_re), 4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
    check("bp_result_count", n_results - nr, 2);

    // Overflow then clean product
    send_product(8, 1'b0, 8, 1'b0, -32768, 0, -32768, 0, 1'b1);
    wait_idle();
    send_product(1, 1'b0, 1, 1'b0, 3, 1, 2, -1, 1'b1);
    wait_idle();

    // Flush mid-product
    nr = n_results;
    send_product(4, 1'b0, 2, 1'b0, 9, 9, 9, 9, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 0);
    @(posedge clk); #1;
    send_product(1, 1'b0, 1, 1'b0, 1, 0, 1, 0, 1'b1);
    wait_idle();
    check("flush_result_count", n_results - nr, 1);

    // Reset mid-product with two stages valid
    nr = n_results;
    send_product(4, 1'b0, 2, 1'b0, 3, 1, 2, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {63'd0, out_valid}, 0);
    check("mrst_busy", {63'd0, busy}, 0);
    check("mrst_res_re", $signed(res_re), 0);
    check("mrst_res_im", $signed(res_im), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_product(1, 1'b1, 1, 1'b0, 7, -2, 3, 5, 1'b1);
    wait_idle();
    check("mrst_result_count", n_results - nr, 1);

    check("sb_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
